// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the configuration SPI read-back path: register map
// addresses, frame geometry and the responder FSM state type.
package spi_cfg_pkg;

   localparam logic [3:0] ADDR_VERSION   = 4'd0;
   localparam logic [3:0] ADDR_CH_ENABLE = 4'd1;
   localparam logic [3:0] ADDR_MODE      = 4'd2;
   localparam logic [3:0] ADDR_COUNT0    = 4'd3;
   localparam logic [3:0] ADDR_DAC0      = 4'd4;
   localparam logic [3:0] ADDR_COUNT1    = 4'd5;
   localparam logic [3:0] ADDR_DAC1      = 4'd6;
   localparam logic [3:0] ADDR_COUNT2    = 4'd7;
   localparam logic [3:0] ADDR_DAC2      = 4'd8;
   localparam logic [3:0] ADDR_COUNT3    = 4'd9;
   localparam logic [3:0] ADDR_DAC3      = 4'd10;
   localparam logic [3:0] ADDR_PRESC     = 4'd11;

   localparam int FRAME_BITS = 24;
   localparam int HDR_BITS   = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_DISCARD,
      ST_DONE
   } rb_state_e;

   // Upper header nibble {R/W, 3'b0}: only a read with the reserved bits clear is answered.
   function automatic logic hdr_is_read(input logic [3:0] ctl);
      return ctl == 4'b1000;
   endfunction

endpackage

// File: rtl/spi_reg_readback_if.sv
// SPI pin bundle between the configuration master and the read-back responder.
interface spi_reg_readback_if;
   logic i_sck;
   logic i_cs_n;
   logic i_mosi;
   logic o_miso;
   logic o_miso_oe;

   modport master (output i_sck, i_cs_n, i_mosi, input o_miso, o_miso_oe);
   modport slave  (input i_sck, i_cs_n, i_mosi, output o_miso, o_miso_oe);
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by a register
// that provides the synchronized level and single-cycle rise/fall events.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Resetting to 0 means a CS held low through reset never looks like a new fall.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q  <= '0;
         o_level <= 1'b0;
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], i_pin};
         o_level <= sync_q[SYNC_STAGES-1];
         o_rise  <= sync_q[SYNC_STAGES-1] & ~o_level;
         o_fall  <= ~sync_q[SYNC_STAGES-1] & o_level;
      end
   end

endmodule

// File: rtl/spi_reg_readback.sv
// Read-direction responder for the configuration SPI link (mode 0, 24-bit frames).
// Optional feature macro SPI_RB_VERSION_EN: address 0 returns VERSION instead of 0.
module spi_reg_readback
   import spi_cfg_pkg::*;
#(
   parameter logic [15:0] VERSION     = 16'h2024,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   spi_reg_readback_if.slave   spi,
   input  logic                i_mod,
   input  logic                i_clk_mod,
   input  logic [7:0]          i_presc,
   input  logic [3:0]          i_ch_enable,
   input  logic [15:0]         i_ch_count0,
   input  logic [15:0]         i_ch_count1,
   input  logic [15:0]         i_ch_count2,
   input  logic [15:0]         i_ch_count3,
   input  logic [7:0]          i_ch_dac0,
   input  logic [7:0]          i_ch_dac1,
   input  logic [7:0]          i_ch_dac2,
   input  logic [7:0]          i_ch_dac3,
   output logic [3:0]          o_rd_addr,
   output logic                o_rd_strobe,
   output logic                o_frame_err
);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(spi.i_sck),
      .o_level(sck_lvl), .o_rise(sck_rise), .o_fall(sck_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(spi.i_cs_n),
      .o_level(cs_lvl), .o_rise(cs_rise), .o_fall(cs_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(spi.i_mosi),
      .o_level(mosi_lvl), .o_rise(mosi_rise), .o_fall(mosi_fall)
   );

   logic unused_pins;
   assign unused_pins = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};

   logic [15:0] ver_word;
`ifdef SPI_RB_VERSION_EN
   assign ver_word = VERSION;
`else
   localparam logic [15:0] unused_version = VERSION;
   assign ver_word = 16'h0000;
`endif

   rb_state_e             state_q;
   logic [4:0]            bit_cnt_q;
   logic [HDR_BITS-2:0]   hdr_q;
   logic [3:0]            rd_addr_q;
   logic                  miso_q, miso_oe_q, rd_strobe_q, frame_err_q;
   logic [15:0]           shift_q;

   logic [HDR_BITS-1:0]   hdr_next;
   logic                  hdr_done, last_rise, hdr_read;
   logic                  shift_load, shift_adv;
   logic [15:0]           map_word;

   assign hdr_next  = {hdr_q, mosi_lvl};
   assign hdr_done  = (bit_cnt_q == 5'(HDR_BITS - 1));
   assign last_rise = (bit_cnt_q == 5'(FRAME_BITS - 1));
   assign hdr_read  = hdr_is_read(hdr_next[7:4]);

   always_comb begin
      map_word = 16'h0000;
      unique case (hdr_next[3:0])
         ADDR_VERSION:   map_word = ver_word;
         ADDR_CH_ENABLE: map_word = {4'b0, i_ch_enable, 8'b0};
         ADDR_MODE:      map_word = {11'b0, i_clk_mod, 3'b0, i_mod};
         ADDR_COUNT0:    map_word = i_ch_count0;
         ADDR_DAC0:      map_word = {8'b0, i_ch_dac0};
         ADDR_COUNT1:    map_word = i_ch_count1;
         ADDR_DAC1:      map_word = {8'b0, i_ch_dac1};
         ADDR_COUNT2:    map_word = i_ch_count2;
         ADDR_DAC2:      map_word = {8'b0, i_ch_dac2};
         ADDR_COUNT3:    map_word = i_ch_count3;
         ADDR_DAC3:      map_word = {8'b0, i_ch_dac3};
         ADDR_PRESC:     map_word = {8'b0, i_presc};
         default:        map_word = 16'h0000;
      endcase
   end

   // A CS rise in the same cycle as an SCK edge discards the edge.
   always_comb begin
      shift_load = (state_q == ST_HEADER) && sck_rise && !cs_rise && hdr_done && hdr_read;
      shift_adv  = (state_q == ST_DATA) && sck_fall && !cs_rise;
   end

   // Snapshot taken once at header completion; later register changes do not reach this frame.
   always_ff @(posedge i_clk) begin
      if (shift_load) begin
         shift_q <= map_word;
      end else if (shift_adv) begin
         shift_q <= {shift_q[14:0], 1'b0};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         hdr_q       <= '0;
         rd_addr_q   <= '0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         rd_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rd_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         if (cs_rise) begin
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            if (state_q inside {ST_HEADER, ST_DATA, ST_DISCARD}) begin
               frame_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state_q   <= ST_HEADER;
                     bit_cnt_q <= '0;
                     miso_oe_q <= 1'b1;
                     miso_q    <= 1'b0;
                  end
               end
               ST_HEADER: begin
                  if (sck_rise) begin
                     hdr_q     <= hdr_next[HDR_BITS-2:0];
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (hdr_done) begin
                        if (hdr_read) begin
                           rd_addr_q   <= hdr_next[3:0];
                           rd_strobe_q <= 1'b1;
                           state_q     <= ST_DATA;
                        end else begin
                           state_q <= ST_DISCARD;
                        end
                     end
                  end
               end
               ST_DATA: begin
                  if (sck_rise) begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (last_rise) begin
                        state_q <= ST_DONE;
                        miso_q  <= 1'b0;
                     end
                  end else if (sck_fall) begin
                     miso_q <= shift_q[15];
                  end
               end
               ST_DISCARD: begin
                  miso_q <= 1'b0;
                  if (sck_rise) begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (last_rise) begin
                        state_q <= ST_DONE;
                     end
                  end
               end
               ST_DONE: begin
                  miso_q <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign spi.o_miso    = miso_q;
   assign spi.o_miso_oe = miso_oe_q;
   assign o_rd_addr     = rd_addr_q;
   assign o_rd_strobe   = rd_strobe_q;
   assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_reg_readback.sv
// Directed bench for spi_reg_readback: SPI frames driven at f_clk/16 with
// hand-computed read-back words.
module tb_spi_reg_readback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mod, clk_mod;
   logic [7:0]  presc;
   logic [3:0]  ch_enable;
   logic [15:0] ch_count0, ch_count1, ch_count2, ch_count3;
   logic [7:0]  ch_dac0, ch_dac1, ch_dac2, ch_dac3;
   logic [3:0]  rd_addr;
   logic        rd_strobe, frame_err;

   spi_reg_readback_if spi_if ();

   spi_reg_readback dut (
      .i_clk(clk), .i_rst_n(rst_n), .spi(spi_if.slave),
      .i_mod(mod), .i_clk_mod(clk_mod), .i_presc(presc), .i_ch_enable(ch_enable),
      .i_ch_count0(ch_count0), .i_ch_count1(ch_count1),
      .i_ch_count2(ch_count2), .i_ch_count3(ch_count3),
      .i_ch_dac0(ch_dac0), .i_ch_dac1(ch_dac1), .i_ch_dac2(ch_dac2), .i_ch_dac3(ch_dac3),
      .o_rd_addr(rd_addr), .o_rd_strobe(rd_strobe), .o_frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_strobe = 0;
   int n_err = 0;
   int n_miso_hi = 0;
   logic [23:0] cap;

   always @(posedge clk) begin
      if (rd_strobe) n_strobe++;
      if (frame_err) n_err++;
      if (spi_if.o_miso) n_miso_hi++;
   end

   task automatic cs_fall_t();
      spi_if.i_cs_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_rise_t();
      repeat (8) @(negedge clk);
      spi_if.i_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Bits first..last of a frame; MISO captured just before each rise into cap[23-i].
   task automatic sck_bits(input logic [23:0] frame, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         spi_if.i_mosi = frame[23-i];
         repeat (8) @(negedge clk);
         cap[23-i] = spi_if.o_miso;
         spi_if.i_sck = 1'b1;
         repeat (8) @(negedge clk);
         spi_if.i_sck = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (spi_if.o_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_if.o_miso); end
      checks++; if (spi_if.o_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_if.o_miso_oe); end
      checks++; if (rd_addr !== 4'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", rd_addr); end
      checks++; if (rd_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", rd_strobe); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_read_count0();
      int s0, e0;
      ch_count0 = 16'hA55A;
      s0 = n_strobe; e0 = n_err;
      cs_fall_t();
      sck_bits(24'h83_0000, 0, 23);
      cs_rise_t();
      checks++; if (n_strobe - s0 != 1) begin failures++; $display("FAIL cnt0_strobes got=%0d exp=1", n_strobe - s0); end
      checks++; if (rd_addr !== 4'h3) begin failures++; $display("FAIL cnt0_addr got=%h exp=3", rd_addr); end
      checks++; if (cap[15:0] !== 16'hA55A) begin failures++; $display("FAIL cnt0_data got=%h exp=a55a", cap[15:0]); end
      checks++; if (cap[23:16] !== 8'h00) begin failures++; $display("FAIL cnt0_hdr_miso got=%h exp=00", cap[23:16]); end
      checks++; if (n_err != e0) begin failures++; $display("FAIL cnt0_err got=%0d exp=0", n_err - e0); end
      checks++; if (spi_if.o_miso_oe !== 1'b0) begin failures++; $display("FAIL cnt0_oe_end got=%b exp=0", spi_if.o_miso_oe); end
   endtask

   task automatic test_version();
      logic [15:0] exp_ver;
`ifdef SPI_RB_VERSION_EN
      exp_ver = 16'h2024;
`else
      exp_ver = 16'h0000;
`endif
      cs_fall_t();
      sck_bits(24'h80_0000, 0, 23);
      cs_rise_t();
      checks++; if (cap[15:0] !== exp_ver) begin failures++; $display("FAIL version_data got=%h exp=%h", cap[15:0], exp_ver); end
      checks++; if (rd_addr !== 4'h0) begin failures++; $display("FAIL version_addr got=%h exp=0", rd_addr); end
   endtask

   task automatic test_write_frame();
      int s0, m0;
      s0 = n_strobe; m0 = n_miso_hi;
      checks++; if (spi_if.o_miso_oe !== 1'b0) begin failures++; $display("FAIL wr_oe_before got=%b exp=0", spi_if.o_miso_oe); end
      cs_fall_t();
      checks++; if (spi_if.o_miso_oe !== 1'b1) begin failures++; $display("FAIL wr_oe_start got=%b exp=1", spi_if.o_miso_oe); end
      sck_bits(24'h04_00FF, 0, 23);
      checks++; if (spi_if.o_miso_oe !== 1'b1) begin failures++; $display("FAIL wr_oe_end got=%b exp=1", spi_if.o_miso_oe); end
      cs_rise_t();
      checks++; if (spi_if.o_miso_oe !== 1'b0) begin failures++; $display("FAIL wr_oe_after got=%b exp=0", spi_if.o_miso_oe); end
      checks++; if (n_strobe != s0) begin failures++; $display("FAIL wr_strobes got=%0d exp=0", n_strobe - s0); end
      checks++; if (n_miso_hi != m0) begin failures++; $display("FAIL wr_miso_high_cycles got=%0d exp=0", n_miso_hi - m0); end
   endtask

   task automatic test_abort();
      int e0;
      e0 = n_err;
      cs_fall_t();
      sck_bits(24'h8B_0000, 0, 11);
      cs_rise_t();
      checks++; if (n_err - e0 != 1) begin failures++; $display("FAIL abort_err_cycles got=%0d exp=1", n_err - e0); end
      checks++; if (spi_if.o_miso_oe !== 1'b0) begin failures++; $display("FAIL abort_oe got=%b exp=0", spi_if.o_miso_oe); end
      checks++; if (spi_if.o_miso !== 1'b0) begin failures++; $display("FAIL abort_miso got=%b exp=0", spi_if.o_miso); end
      presc = 8'h03;
      e0 = n_err;
      cs_fall_t();
      sck_bits(24'h8B_0000, 0, 23);
      cs_rise_t();
      checks++; if (cap[15:0] !== 16'h0003) begin failures++; $display("FAIL presc_data got=%h exp=0003", cap[15:0]); end
      checks++; if (rd_addr !== 4'hB) begin failures++; $display("FAIL presc_addr got=%h exp=b", rd_addr); end
      checks++; if (n_err != e0) begin failures++; $display("FAIL presc_err got=%0d exp=0", n_err - e0); end
   endtask

   task automatic test_snapshot();
      ch_dac2 = 8'hFF;
      cs_fall_t();
      sck_bits(24'h88_0000, 0, 11);
      ch_dac2 = 8'h10;
      sck_bits(24'h88_0000, 12, 23);
      cs_rise_t();
      checks++; if (cap[15:0] !== 16'h00FF) begin failures++; $display("FAIL snapshot_data got=%h exp=00ff", cap[15:0]); end
      checks++; if (rd_addr !== 4'h8) begin failures++; $display("FAIL snapshot_addr got=%h exp=8", rd_addr); end
   endtask

   task automatic test_reset_midframe();
      int s0, m0, e0;
      cs_fall_t();
      sck_bits(24'h89_0000, 0, 14);
      rst_n = 1'b0;
      #1;
      checks++; if (spi_if.o_miso !== 1'b0) begin failures++; $display("FAIL rstmid_miso got=%b exp=0", spi_if.o_miso); end
      checks++; if (spi_if.o_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe got=%b exp=0", spi_if.o_miso_oe); end
      checks++; if (rd_addr !== 4'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", rd_addr); end
      checks++; if (rd_strobe !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_pulses got=%b%b exp=00", rd_strobe, frame_err); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      s0 = n_strobe; m0 = n_miso_hi; e0 = n_err;
      sck_bits(24'h89_0000, 15, 23);
      checks++; if (spi_if.o_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe_rest got=%b exp=0", spi_if.o_miso_oe); end
      checks++; if (n_miso_hi != m0 || n_strobe != s0) begin failures++; $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0", n_miso_hi - m0, n_strobe - s0); end
      cs_rise_t();
      checks++; if (n_err != e0) begin failures++; $display("FAIL rstmid_err got=%0d exp=0", n_err - e0); end
      mod = 1'b1; clk_mod = 1'b1;
      cs_fall_t();
      sck_bits(24'h82_0000, 0, 23);
      cs_rise_t();
      checks++; if (cap[15:0] !== 16'h0011) begin failures++; $display("FAIL mode_data got=%h exp=0011", cap[15:0]); end
   endtask

   task automatic test_back_to_back();
      ch_enable = 4'hA;
      ch_count3 = 16'h1234;
      cs_fall_t();
      sck_bits(24'h81_0000, 0, 23);
      cs_rise_t();
      checks++; if (cap[15:0] !== 16'h0A00) begin failures++; $display("FAIL enable_data got=%h exp=0a00", cap[15:0]); end
      cs_fall_t();
      sck_bits(24'h89_0000, 0, 23);
      cs_rise_t();
      checks++; if (cap[15:0] !== 16'h1234) begin failures++; $display("FAIL count3_data got=%h exp=1234", cap[15:0]); end
      cs_fall_t();
      sck_bits(24'h8D_0000, 0, 23);
      cs_rise_t();
      checks++; if (cap[15:0] !== 16'h0000) begin failures++; $display("FAIL addr13_data got=%h exp=0000", cap[15:0]); end
      checks++; if (rd_addr !== 4'hD) begin failures++; $display("FAIL addr13_addr got=%h exp=d", rd_addr); end
   endtask

   initial begin
      spi_if.i_sck = 1'b0; spi_if.i_cs_n = 1'b1; spi_if.i_mosi = 1'b0;
      mod = 1'b0; clk_mod = 1'b0; presc = 8'h5C; ch_enable = 4'h0;
      ch_count0 = 16'h0; ch_count1 = 16'hFFFF; ch_count2 = 16'hFFFF; ch_count3 = 16'h0;
      ch_dac0 = 8'hFF; ch_dac1 = 8'hFF; ch_dac2 = 8'h0; ch_dac3 = 8'hFF;
      test_reset();
      test_read_count0();
      test_version();
      test_write_frame();
      test_abort();
      test_snapshot();
      test_reset_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
